// File: rtl/zebra_detect_sequencer.sv
// Sequences one zebra-crossing detection per frame: clear visited BRAM, run detector, publish result.
// Latency: TOTAL clear cycles, then up to TIMEOUT_CYCLES run cycles, then a one-cycle DONE result pulse.
// Backpressure: frame_ready while busy is held as one pending frame; extra pulses collapse into it.
module zebra_detect_sequencer #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int TOTAL          = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_W         = $clog2(TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_ready,
  output logic              busy,
  output logic              det_valid_to_read,
  input  logic              det_detection_valid,
  input  logic              det_crossing_detected,
  input  logic [7:0]        det_stripe_count,
  input  logic [ADDR_W-1:0] det_visited_addr,
  input  logic              det_visited_we,
  input  logic              det_visited_wdata,
  output logic [ADDR_W-1:0] mem_visited_addr,
  output logic              mem_visited_we,
  output logic              mem_visited_wdata,
  output logic              result_valid,
  output logic              result_crossing,
  output logic [7:0]        result_stripes,
  output logic              result_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  // Terminal counts: last clear address and last allowed run cycle.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(TOTAL - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [ADDR_W:0] clr_cnt, clr_cnt_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            pending, pending_nxt;
  logic            load_det;
  logic            load_to;

  // State, counters and pending flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      to_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      pending <= pending_nxt;
    end
  end

  // Next-state, counter updates and all combinational outputs.
  always_comb begin
    state_nxt         = state;
    clr_cnt_nxt       = clr_cnt;
    to_cnt_nxt        = to_cnt;
    pending_nxt       = pending;
    load_det          = 1'b0;
    load_to           = 1'b0;
    busy              = (state != S_IDLE);
    det_valid_to_read = 1'b0;
    mem_visited_addr  = '0;
    mem_visited_we    = 1'b0;
    mem_visited_wdata = 1'b0;
    result_valid      = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_ready || pending) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
          pending_nxt = 1'b0;
        end
      end

      S_CLEAR: begin
        pending_nxt       = pending | frame_ready;
        mem_visited_addr  = clr_cnt[ADDR_W-1:0];
        mem_visited_we    = 1'b1;
        mem_visited_wdata = 1'b0;
        if (clr_cnt == CLR_LAST) begin
          state_nxt  = S_RUN;
          to_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end

      S_RUN: begin
        pending_nxt       = pending | frame_ready;
        det_valid_to_read = 1'b1;
        // Detector owns the visited BRAM port with no added latency.
        mem_visited_addr  = det_visited_addr;
        mem_visited_we    = det_visited_we;
        mem_visited_wdata = det_visited_wdata;
        // A detection on the final allowed cycle still counts as a detection.
        if (det_detection_valid) begin
          state_nxt = S_DONE;
          load_det  = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_DONE;
          load_to   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      S_DONE: begin
        result_valid = 1'b1;
        pending_nxt  = 1'b0;
        if (pending || frame_ready) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result fields update only on entry to DONE and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_crossing <= 1'b0;
      result_stripes  <= 8'd0;
      result_timeout  <= 1'b0;
    end else if (load_det) begin
      result_crossing <= det_crossing_detected;
      result_stripes  <= det_stripe_count;
      result_timeout  <= 1'b0;
    end else if (load_to) begin
      result_crossing <= 1'b0;
      result_stripes  <= 8'd0;
      result_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zebra_detect_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a phase/elapsed-cycle reference model.
module tb_zebra_detect_sequencer;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int TOTAL  = W * H;
  localparam int TMO    = 100;
  localparam int ADDR_W = $clog2(TOTAL);

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;

  logic              clk;
  logic              rst;
  logic              frame_ready;
  logic              busy;
  logic              det_valid_to_read;
  logic              det_detection_valid;
  logic              det_crossing_detected;
  logic [7:0]        det_stripe_count;
  logic [ADDR_W-1:0] det_visited_addr;
  logic              det_visited_we;
  logic              det_visited_wdata;
  logic [ADDR_W-1:0] mem_visited_addr;
  logic              mem_visited_we;
  logic              mem_visited_wdata;
  logic              result_valid;
  logic              result_crossing;
  logic [7:0]        result_stripes;
  logic              result_timeout;

  int checks   = 0;
  int failures = 0;

  zebra_detect_sequencer #(
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_ready(frame_ready),
    .busy(busy),
    .det_valid_to_read(det_valid_to_read),
    .det_detection_valid(det_detection_valid),
    .det_crossing_detected(det_crossing_detected),
    .det_stripe_count(det_stripe_count),
    .det_visited_addr(det_visited_addr),
    .det_visited_we(det_visited_we),
    .det_visited_wdata(det_visited_wdata),
    .mem_visited_addr(mem_visited_addr),
    .mem_visited_we(mem_visited_we),
    .mem_visited_wdata(mem_visited_wdata),
    .result_valid(result_valid),
    .result_crossing(result_crossing),
    .result_stripes(result_stripes),
    .result_timeout(result_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the sequencer is in, how many cycles it has
  // spent there, whether another frame is waiting, and the last published result.
  int         m_phase;
  int         m_idx;
  bit         m_pend;
  logic       m_cross;
  logic [7:0] m_str;
  logic       m_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_idx   = 0;
      m_pend  = 0;
      m_cross = 0;
      m_str   = 0;
      m_tmo   = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (frame_ready || m_pend) begin
            m_phase = P_CLEAR;
            m_idx   = 0;
            m_pend  = 0;
          end
        end
        P_CLEAR: begin
          if (frame_ready) m_pend = 1;
          if (m_idx == TOTAL - 1) begin
            m_phase = P_RUN;
            m_idx   = 0;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        P_RUN: begin
          if (frame_ready) m_pend = 1;
          if (det_detection_valid) begin
            m_phase = P_DONE;
            m_cross = det_crossing_detected;
            m_str   = det_stripe_count;
            m_tmo   = 0;
          end else if (m_idx + 1 >= TMO) begin
            m_phase = P_DONE;
            m_cross = 0;
            m_str   = 0;
            m_tmo   = 1;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        default: begin
          if (frame_ready || m_pend) begin
            m_phase = P_CLEAR;
            m_idx   = 0;
          end else begin
            m_phase = P_IDLE;
          end
          m_pend = 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, (m_phase != P_IDLE));
      chk("det_valid_to_read", det_valid_to_read, (m_phase == P_RUN));
      chk("result_valid", result_valid, (m_phase == P_DONE));
      if (m_phase == P_CLEAR) begin
        chk("clear_we", mem_visited_we, 1);
        chk("clear_addr", mem_visited_addr, m_idx);
        chk("clear_wdata", mem_visited_wdata, 0);
      end else if (m_phase == P_RUN) begin
        chk("run_we", mem_visited_we, det_visited_we);
        chk("run_addr", mem_visited_addr, det_visited_addr);
        chk("run_wdata", mem_visited_wdata, det_visited_wdata);
      end else begin
        chk("idle_we", mem_visited_we, 0);
        chk("idle_addr", mem_visited_addr, 0);
        chk("idle_wdata", mem_visited_wdata, 0);
      end
      chk("result_crossing", result_crossing, m_cross);
      chk("result_stripes", result_stripes, m_str);
      chk("result_timeout", result_timeout, m_tmo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_det();
    det_detection_valid   = 0;
    det_crossing_detected = 0;
    det_stripe_count      = 0;
    det_visited_addr      = 0;
    det_visited_we        = 0;
    det_visited_wdata     = 0;
  endtask

  task automatic wait_run(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc();
      #1;
      ok = det_valid_to_read;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      cyc();
      #1;
      ok = !busy;
    end
    chk(name, ok, 1);
  endtask

  task automatic pulse_frame();
    frame_ready = 1;
    cyc();
    frame_ready = 0;
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int run_cycles;
    int writes;
    int pulses;
    bit found;

    rst         = 1;
    frame_ready = 0;
    quiet_det();
    #1;
    // Reset values while reset is held.
    chk("rst_busy", busy, 0);
    chk("rst_det_valid", det_valid_to_read, 0);
    chk("rst_we", mem_visited_we, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_timeout", result_timeout, 0);
    cyc();
    cyc();
    rst = 0;
    cyc();

    // Clear sweep then a detection with crossing=1, stripes=5.
    pulse_frame();
    chk("first_write_we", mem_visited_we, 1);
    chk("first_write_addr", mem_visited_addr, 0);
    for (int i = 1; i < TOTAL; i++) begin
      cyc();
      #1;
      chk("sweep_addr", {mem_visited_we, 5'd0, mem_visited_addr}, {1'b1, 5'd0, 5'(i)});
    end
    cyc();
    #1;
    chk("run_after_addr31", det_valid_to_read, 1);
    det_detection_valid   = 1;
    det_crossing_detected = 1;
    det_stripe_count      = 8'd5;
    cyc();
    quiet_det();
    #1;
    chk("det_result_valid", result_valid, 1);
    chk("det_result_crossing", result_crossing, 1);
    chk("det_result_stripes", result_stripes, 5);
    chk("det_result_timeout", result_timeout, 0);
    cyc();
    #1;
    chk("det_back_idle_busy", busy, 0);
    chk("det_pulse_one_cycle", result_valid, 0);
    chk("det_result_held", result_stripes, 5);

    // Silent detector: exactly TMO run cycles, then a timeout result.
    pulse_frame();
    wait_run("wait_run_timeout_case");
    run_cycles = 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc();
      #1;
      if (result_valid) found = 1;
      else if (det_valid_to_read) run_cycles++;
    end
    chk("timeout_seen", found, 1);
    chk("timeout_run_cycles", run_cycles, TMO);
    chk("timeout_flag", result_timeout, 1);
    chk("timeout_crossing", result_crossing, 0);
    chk("timeout_stripes", result_stripes, 0);
    wait_idle("idle_after_timeout");

    // Detection on the very last allowed cycle beats the timeout.
    pulse_frame();
    wait_run("wait_run_edge_case");
    for (int i = 1; i < TMO; i++) cyc();
    #1;
    chk("edge_still_running", det_valid_to_read, 1);
    det_detection_valid   = 1;
    det_crossing_detected = 1;
    det_stripe_count      = 8'd7;
    cyc();
    quiet_det();
    #1;
    chk("edge_result_valid", result_valid, 1);
    chk("edge_timeout", result_timeout, 0);
    chk("edge_stripes", result_stripes, 7);
    wait_idle("idle_after_edge");

    // Three frame_ready pulses during RUN collapse into one extra frame.
    pulse_frame();
    wait_run("wait_run_pending_case");
    for (int p = 0; p < 3; p++) begin
      frame_ready = 1;
      cyc();
      frame_ready = 0;
      cyc();
    end
    det_detection_valid   = 1;
    det_crossing_detected = 0;
    det_stripe_count      = 8'd3;
    cyc();
    quiet_det();
    #1;
    chk("pending_first_result", result_valid, 1);
    writes = 0;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      cyc();
      #1;
      if (mem_visited_we) writes++;
      if (result_valid) pulses++;
    end
    chk("pending_extra_writes", writes, TOTAL);
    chk("pending_extra_results", pulses, 1);
    chk("pending_end_idle", busy, 0);

    // Asynchronous reset in the middle of the clear sweep.
    pulse_frame();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_visited_we && mem_visited_addr == 5'd10) found = 1;
      else begin
        cyc();
        #1;
      end
    end
    chk("reached_addr10", found, 1);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", mem_visited_we, 0);
    chk("arst_det_valid", det_valid_to_read, 0);
    chk("arst_result_valid", result_valid, 0);
    chk("arst_result_timeout", result_timeout, 0);
    chk("arst_result_stripes", result_stripes, 0);
    cyc();
    cyc();
    rst = 0;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      if (mem_visited_we) writes++;
    end
    chk("no_writes_after_reset", writes, 0);
    pulse_frame();
    chk("restart_addr0", {mem_visited_we, 2'd0, mem_visited_addr}, {1'b1, 2'd0, 5'd0});
    wait_idle("idle_after_restart");

    // Randomized traffic checked by the model/compare process.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst                   = ($urandom_range(0, 1499) == 0);
      frame_ready           = ($urandom_range(0, 39) == 0);
      det_visited_addr      = 5'($urandom_range(0, TOTAL - 1));
      det_visited_we        = 1'($urandom_range(0, 1));
      det_visited_wdata     = 1'($urandom_range(0, 1));
      det_crossing_detected = 1'($urandom_range(0, 1));
      det_stripe_count      = 8'($urandom_range(0, 255));
      det_detection_valid   = (m_phase == P_RUN) && ($urandom_range(0, 59) == 0);
    end
    cyc();
    rst         = 0;
    frame_ready = 0;
    quiet_det();
    wait_idle("idle_after_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
